timed_future_eventually_monitor: RTL and testbench

//  Streaming monitor for the bounded future-time MTL operator F[A,B] phi.
//  For each trace position i, it emits y(i)=1 iff there is a j in [i+A, i+B]

---
 rtl/timed_future_eventually_monitor_if.sv | 22 ++
 rtl/timed_future_eventually_monitor.sv | 112 +++++++++++
 tb/tb_timed_future_eventually_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timed_future_eventually_monitor_if.sv
// Handshake bundle for the bounded-future monitor: trace samples in, verdicts out.
// The master drives samples and accepts verdicts; the slave is the monitor itself.
interface timed_future_eventually_monitor_if;
  logic in_valid;
  logic in_ready;
  logic in_phi;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic out_y;
  logic out_last;

  modport master (
    output in_valid, in_phi, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_last
  );

  modport slave (
    input  in_valid, in_phi, in_last, out_ready,
    output in_ready, out_valid, out_y, out_last
  );
endinterface

// File: rtl/timed_future_eventually_monitor.sv
// Streaming monitor for F[A,B] phi: y(i)=1 iff phi holds somewhere in [i+A, i+B].
// Buffers B+1 samples, emits verdicts in order and pads with phi=0 at trace end.
module timed_future_eventually_monitor #(
  parameter int A = 1,
  parameter int B = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  timed_future_eventually_monitor_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [B:0] h_q, h_d, v_q, v_d;
  logic [B:0] h_sh, v_sh;
  logic       out_valid_q, out_valid_d;
  logic       out_y_q, out_y_d;
  logic       out_last_q, out_last_d;
  logic       free, in_ready, accept, shift;
  logic       window, younger, closing, emit, emit_last;

  assign free     = !out_valid_q || bus.out_ready;
  assign in_ready = free && (state_q == RUN);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_last  = out_last_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    h_d         = h_q;
    v_d         = v_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;

    accept = bus.in_valid && in_ready;
    shift  = (state_q == RUN) ? accept : free;

    // Index 0 is the newest position; FLUSH inserts padding that never becomes a verdict.
    h_sh[0] = (state_q == RUN) ? bus.in_phi : 1'b0;
    v_sh[0] = (state_q == RUN);
    for (int k = 1; k <= B; k++) begin
      h_sh[k] = h_q[k-1];
      v_sh[k] = v_q[k-1];
    end

    // Oldest position i sits at B, so positions i+A..i+B are indices B-A..0.
    window = 1'b0;
    for (int k = 0; k <= B - A; k++) begin
      window = window | h_sh[k];
    end

    younger = 1'b0;
    for (int k = 0; k < B; k++) begin
      younger = younger | v_sh[k];
    end

    closing   = (state_q == FLUSH) || (accept && bus.in_last);
    emit      = shift && v_sh[B];
    emit_last = emit && closing && !younger;

    if (shift) begin
      h_d = h_sh;
      v_d = v_sh;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_y_d     = window;
      out_last_d  = emit_last;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // With B=0 the final verdict leaves together with in_last, so FLUSH is skipped.
    if (accept && bus.in_last && !emit_last) begin
      state_d = FLUSH;
    end else if ((state_q == FLUSH) && emit_last) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the history is a handful of flops, so it is cleared on reset; stale
    // valid bits would otherwise produce verdicts for a trace that was abandoned.
    if (!rst_ni) begin
      state_q     <= RUN;
      h_q         <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_timed_future_eventually_monitor.sv
// Bench for timed_future_eventually_monitor: four (A,B) instances behind one shared
// driver, table vectors, hand sequences for stalls/reset/back-to-back, random traces.
module tb_timed_future_eventually_monitor;

  localparam int NCFG = 4;
  localparam int CFG_A [NCFG] = '{1, 0, 0, 2};
  localparam int CFG_B [NCFG] = '{3, 2, 0, 2};

  typedef struct {
    logic [1:0]  cfg;
    int          n;
    logic [15:0] phi;
    logic [15:0] y;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_phi = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [1:0] sel = 2'd0;
  bit         rand_rdy = 1'b0;
  logic       in_ready, out_valid, out_y, out_last;
  logic       rdy_a [NCFG];
  logic       ov_a  [NCFG];
  logic       oy_a  [NCFG];
  logic       ol_a  [NCFG];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    timed_future_eventually_monitor_if bus ();
    assign bus.in_valid  = in_valid && (sel == 2'(g));
    assign bus.in_phi    = in_phi;
    assign bus.in_last   = in_last;
    assign bus.out_ready = out_ready;
    assign rdy_a[g]      = bus.in_ready;
    assign ov_a[g]       = bus.out_valid;
    assign oy_a[g]       = bus.out_y;
    assign ol_a[g]       = bus.out_last;

    timed_future_eventually_monitor #(
      .A (CFG_A[g]),
      .B (CFG_B[g])
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
    );
  end

  assign in_ready  = rdy_a[sel];
  assign out_valid = ov_a[sel];
  assign out_y     = oy_a[sel];
  assign out_last  = ol_a[sel];

  // Reference model: the accepted samples of the current trace and the verdicts seen so far.
  logic trace_q [$];
  logic obs_q   [$];
  int   n_done   = 0;
  int   n_last   = 0;
  bit   ended    = 1'b0;
  bit   flushing = 1'b0;
  bit   hold_q   = 1'b0;
  logic hold_y, hold_last;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // y(k) = OR of phi(j) for j in [k+A, k+B], positions past the trace end count as 0.
  task automatic consume();
    int   k  = n_done;
    int   n  = trace_q.size();
    int   ca = CFG_A[sel];
    int   cb = CFG_B[sel];
    logic exp_y = 1'b0;
    logic exp_last;
    bit   timing_ok;
    obs_q.push_back(out_y);
    timing_ok = ended ? (k < n) : (n > k + cb);
    check("verdict_timing", timing_ok, 1'b1);
    for (int j = k + ca; j <= k + cb; j++) begin
      if (j < n) exp_y = exp_y | trace_q[j];
    end
    exp_last = ended && (k == n - 1);
    check("verdict_y", out_y, exp_y);
    check("verdict_last", out_last, exp_last);
    if (out_last) n_last++;
    n_done++;
    if (ended && n_done >= n) begin
      trace_q.delete();
      n_done = 0;
      ended  = 1'b0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      trace_q.delete();
      n_done   = 0;
      ended    = 1'b0;
      flushing = 1'b0;
      hold_q   = 1'b0;
    end else begin
      if (flushing && out_valid && out_last) flushing = 1'b0;
      if (flushing) check("in_ready_during_flush", in_ready, 1'b0);
      if (hold_q) begin
        check("held_valid", out_valid, 1'b1);
        check("held_y", out_y, hold_y);
        check("held_last", out_last, hold_last);
      end
      if (out_valid && out_ready) consume();
      if (in_valid && in_ready) begin
        trace_q.push_back(in_phi);
        if (in_last) begin
          ended    = 1'b1;
          flushing = 1'b1;
        end
      end
      hold_q    = out_valid && !out_ready;
      hold_y    = out_y;
      hold_last = out_last;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one sample and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic push(input logic phi, input logic last, input int gap);
    int t = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_phi   = phi;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bit done;
    while ((ended || trace_q.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    done = !(ended || trace_q.size() != 0 || out_valid);
    check("drain_done", done, 1'b1);
  endtask

  task automatic run_trace(input logic [1:0] cfg, input int n, input logic [15:0] phi,
                           input bit rnd);
    sel = cfg;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      push(phi[i], i == n - 1, rnd ? int'($urandom_range(0, 2)) : 0);
    end
    drain();
    check_int("verdict_count", obs_q.size(), n);
  endtask

  initial begin
    vec_t tbl [6];
    int   l0;
    logic [15:0] p;
    logic [2:0]  t4;

    tbl[0] = '{2'd0, 7, 16'b0000100, 16'b0000011};
    tbl[1] = '{2'd0, 1, 16'b1,       16'b0};
    tbl[2] = '{2'd1, 5, 16'b10001,   16'b11101};
    tbl[3] = '{2'd2, 3, 16'b101,     16'b101};
    tbl[4] = '{2'd3, 6, 16'b110100,  16'b001101};
    tbl[5] = '{2'd1, 1, 16'b1,       16'b1};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int c = 0; c < NCFG; c++) begin
      sel = 2'(c);
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_y", out_y, 1'b0);
      check("reset_out_last", out_last, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
    end
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      l0 = n_last;
      run_trace(tbl[v].cfg, tbl[v].n, tbl[v].phi, 1'b0);
      for (int i = 0; i < tbl[v].n && i < obs_q.size(); i++) begin
        check("tbl_y", obs_q[i], tbl[v].y[i]);
      end
      check_int("tbl_last_count", n_last - l0, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_single", out_valid, 1'b0);

    // Backpressure mid-trace: verdict y(0) must stay put and input must stall.
    sel = 2'd1;
    obs_q.delete();
    push(1'b1, 1'b0, 0);
    push(1'b0, 1'b0, 0);
    push(1'b0, 1'b0, 0);
    check("stall_first_valid", out_valid, 1'b1);
    check("stall_first_y", out_y, 1'b1);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_y_stable", out_y, 1'b1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(1'b0, 1'b0, 0);
    push(1'b1, 1'b1, 0);
    drain();
    check_int("stall_count", obs_q.size(), 5);
    p = 16'b11101;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) check("stall_y", obs_q[i], p[i]);

    // B=0: each verdict is visible one cycle after its sample is accepted.
    sel = 2'd2;
    obs_q.delete();
    t4 = 3'b101;
    for (int i = 0; i < 3; i++) begin
      push(t4[i], i == 2, 0);
      check("b0_latency_valid", out_valid, 1'b1);
      check("b0_latency_y", out_y, t4[i]);
    end
    check("b0_last", out_last, 1'b1);
    drain();

    // Reset in the middle of a flush drops the pending verdicts.
    sel = 2'd0;
    obs_q.delete();
    push(1'b1, 1'b0, 0);
    push(1'b0, 1'b1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("flush_reset_valid", out_valid, 1'b0);
    check("flush_reset_last", out_last, 1'b0);
    check("flush_reset_ready", in_ready, 1'b1);
    obs_q.delete();
    push(1'b0, 1'b1, 0);
    drain();
    check_int("after_reset_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("after_reset_y", obs_q[0], 1'b0);

    // Two traces back to back; the second sample waits out the first flush.
    l0 = n_last;
    obs_q.delete();
    push(1'b1, 1'b0, 0);
    push(1'b1, 1'b1, 0);
    push(1'b0, 1'b1, 0);
    drain();
    check_int("b2b_count", obs_q.size(), 3);
    p = 16'b001;
    for (int i = 0; i < 3 && i < obs_q.size(); i++) check("b2b_y", obs_q[i], p[i]);
    check_int("b2b_last_count", n_last - l0, 2);

    // Random traces under random backpressure, checked by the reference model.
    rand_rdy = 1'b1;
    for (int r = 0; r < 60; r++) begin
      run_trace(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 16'($urandom), 1'b1);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
